// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: shared constants and types for the instruction sequencer.
//   - 8-bit state-word encodings consumed by the control decoder
//   - 5-bit opcode constants (5'h00..5'h0F legal, 5'h10 and up illegal)
//   - FSM phase enum, ROM entry struct, IO-state helper
package instr_sequencer_pkg;

  // State words (existing encodings plus STATE_DECODE)
  localparam logic [7:0] STATE_FETCH_PC   = 8'h01;
  localparam logic [7:0] STATE_FETCH_INST = 8'h02;
  localparam logic [7:0] STATE_ALU_EXEC   = 8'h03;
  localparam logic [7:0] STATE_ALU_OUT    = 8'h04;
  localparam logic [7:0] STATE_SET_REG    = 8'h05;
  localparam logic [7:0] STATE_LOAD_ADDR  = 8'h06;
  localparam logic [7:0] STATE_SET_MEM    = 8'h07;
  localparam logic [7:0] STATE_SET_MAR    = 8'h08;
  localparam logic [7:0] STATE_MOVE_REG   = 8'h09;
  localparam logic [7:0] STATE_FETCH_SP   = 8'h0A;
  localparam logic [7:0] STATE_STACK_REG  = 8'h0B;
  localparam logic [7:0] STATE_INC_SP     = 8'h0C;
  localparam logic [7:0] STATE_JUMP       = 8'h0D;
  localparam logic [7:0] STATE_STORE_PC   = 8'h0E;
  localparam logic [7:0] STATE_TMP_JUMP   = 8'h0F;
  localparam logic [7:0] STATE_RET        = 8'h10;
  localparam logic [7:0] STATE_MOUT_STORE = 8'h11;
  localparam logic [7:0] STATE_ROUT_STORE = 8'h12;
  localparam logic [7:0] STATE_HALT       = 8'h13;
  localparam logic [7:0] STATE_DECODE     = 8'h14;

  // Opcodes
  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ALU  = 5'h01;
  localparam logic [4:0] OP_LDI  = 5'h02;
  localparam logic [4:0] OP_LD   = 5'h03;
  localparam logic [4:0] OP_ST   = 5'h04;
  localparam logic [4:0] OP_LDR  = 5'h05;
  localparam logic [4:0] OP_STR  = 5'h06;
  localparam logic [4:0] OP_MOV  = 5'h07;
  localparam logic [4:0] OP_PUSH = 5'h08;
  localparam logic [4:0] OP_POP  = 5'h09;
  localparam logic [4:0] OP_JMP  = 5'h0A;
  localparam logic [4:0] OP_CALL = 5'h0B;
  localparam logic [4:0] OP_RET  = 5'h0C;
  localparam logic [4:0] OP_MOUT = 5'h0D;
  localparam logic [4:0] OP_ROUT = 5'h0E;
  localparam logic [4:0] OP_HALT = 5'h0F;
  localparam logic [4:0] OP_ILLEGAL_MIN = 5'h10;

  typedef enum logic [2:0] {
    PH_FETCH_PC   = 3'd0,
    PH_FETCH_INST = 3'd1,
    PH_DECODE     = 3'd2,
    PH_EXEC       = 3'd3,
    PH_HALT       = 3'd4
  } phase_t;

  typedef struct packed {
    logic [7:0] word;
    logic       last;
    logic       legal;
  } rom_entry_t;

  // States that wait for the IO handshake before advancing
  function automatic logic is_io_state(input logic [7:0] word);
    return (word == STATE_MOUT_STORE) || (word == STATE_ROUT_STORE);
  endfunction

endpackage

// File: rtl/instr_sequencer_seq_rom.sv
// seq_rom: combinational execute-sequence table.
//   op    in  OPC_W   opcode to look up
//   step  in  STEP_W  execute step index
//   entry out         {state word, last-step flag, opcode-legal flag}
// NOP is encoded as a single FETCH_PC step flagged last, so the caller
// can retire it straight from DECODE.
module seq_rom
  import instr_sequencer_pkg::*;
#(
  parameter int OPC_W  = 5,
  parameter int STEP_W = 2
) (
  input  logic [OPC_W-1:0]  op,
  input  logic [STEP_W-1:0] step,
  output rom_entry_t        entry
);

  logic [7:0] w0;
  logic [7:0] w1;
  logic [7:0] w2;
  logic [1:0] last_idx;
  logic       legal;

  // Per-opcode sequence table
  always_comb begin
    w0       = STATE_FETCH_PC;
    w1       = STATE_FETCH_PC;
    w2       = STATE_FETCH_PC;
    last_idx = 2'd0;
    legal    = 1'b1;
    case (op)
      OP_NOP:  last_idx = 2'd0;
      OP_ALU:  begin w0 = STATE_ALU_EXEC;  w1 = STATE_ALU_OUT;   last_idx = 2'd1; end
      OP_LDI:  begin w0 = STATE_FETCH_PC;  w1 = STATE_SET_REG;   last_idx = 2'd1; end
      OP_LD:   begin w0 = STATE_FETCH_PC;  w1 = STATE_LOAD_ADDR; w2 = STATE_SET_REG;    last_idx = 2'd2; end
      OP_ST:   begin w0 = STATE_FETCH_PC;  w1 = STATE_LOAD_ADDR; w2 = STATE_SET_MEM;    last_idx = 2'd2; end
      OP_LDR:  begin w0 = STATE_SET_MAR;   w1 = STATE_SET_REG;   last_idx = 2'd1; end
      OP_STR:  begin w0 = STATE_SET_MAR;   w1 = STATE_SET_MEM;   last_idx = 2'd1; end
      OP_MOV:  begin w0 = STATE_MOVE_REG;  last_idx = 2'd0; end
      OP_PUSH: begin w0 = STATE_FETCH_SP;  w1 = STATE_STACK_REG; last_idx = 2'd1; end
      OP_POP:  begin w0 = STATE_INC_SP;    w1 = STATE_FETCH_SP;  w2 = STATE_SET_REG;    last_idx = 2'd2; end
      OP_JMP:  begin w0 = STATE_FETCH_PC;  w1 = STATE_JUMP;      last_idx = 2'd1; end
      OP_CALL: begin w0 = STATE_FETCH_SP;  w1 = STATE_STORE_PC;  w2 = STATE_TMP_JUMP;   last_idx = 2'd2; end
      OP_RET:  begin w0 = STATE_INC_SP;    w1 = STATE_FETCH_SP;  w2 = STATE_RET;        last_idx = 2'd2; end
      OP_MOUT: begin w0 = STATE_FETCH_PC;  w1 = STATE_LOAD_ADDR; w2 = STATE_MOUT_STORE; last_idx = 2'd2; end
      OP_ROUT: begin w0 = STATE_ROUT_STORE; last_idx = 2'd0; end
      OP_HALT: begin w0 = STATE_HALT;      last_idx = 2'd0; end
      default: begin w0 = STATE_HALT;      legal = 1'b0; end
    endcase
  end

  // Select the word for the requested step
  always_comb begin
    entry.legal = legal;
    entry.last  = (2'(step) == last_idx);
    if (step == STEP_W'(0)) begin
      entry.word = w0;
    end else if (step == STEP_W'(1)) begin
      entry.word = w1;
    end else begin
      entry.word = w2;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: micro-sequencer producing the control-decoder state word.
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   en          in   run enable; low freezes every register
//   opcode      in   IR opcode, sampled in DECODE only
//   io_ack      in   IO transfer accepted (used in MOUT_STORE/ROUT_STORE)
//   state       out  registered state word
//   instr_done  out  one-cycle pulse in the FETCH_PC after retirement
//   fault       out  sticky illegal-opcode flag
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int OPC_W     = 5,
  parameter int MAX_STEPS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [OPC_W-1:0] opcode,
  input  logic             io_ack,
  output logic [7:0]       state,
  output logic             instr_done,
  output logic             fault
);

  localparam int STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

  phase_t            phase;
  logic [STEP_W-1:0] step;
  logic [OPC_W-1:0]  op_q;
  logic              last_q;   // current exec state is the final one

  logic [OPC_W-1:0]  rom_op;
  logic [STEP_W-1:0] rom_step;
  rom_entry_t        rom_out;

  // ROM looks ahead: first step of the incoming opcode in DECODE,
  // otherwise the step after the current one of the latched opcode
  always_comb begin
    if (phase == PH_DECODE) begin
      rom_op   = opcode;
      rom_step = '0;
    end else begin
      rom_op   = op_q;
      rom_step = step + STEP_W'(1);
    end
  end

  seq_rom #(.OPC_W(OPC_W), .STEP_W(STEP_W)) u_rom (
    .op    (rom_op),
    .step  (rom_step),
    .entry (rom_out)
  );

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= PH_FETCH_PC;
      state      <= STATE_FETCH_PC;
      step       <= '0;
      op_q       <= OPC_W'(OP_NOP);
      last_q     <= 1'b0;
      instr_done <= 1'b0;
      fault      <= 1'b0;
    end else if (en) begin
      instr_done <= 1'b0;
      case (phase)
        PH_FETCH_PC: begin
          phase <= PH_FETCH_INST;
          state <= STATE_FETCH_INST;
        end
        PH_FETCH_INST: begin
          phase <= PH_DECODE;
          state <= STATE_DECODE;
        end
        PH_DECODE: begin
          op_q   <= opcode;
          step   <= '0;
          last_q <= rom_out.last;
          if (!rom_out.legal) begin
            phase <= PH_HALT;
            state <= STATE_HALT;
            fault <= 1'b1;
          end else if (rom_out.word == STATE_HALT) begin
            phase <= PH_HALT;
            state <= STATE_HALT;
          end else if (rom_out.last && (rom_out.word == STATE_FETCH_PC)) begin
            // NOP: retires with no execute states
            phase      <= PH_FETCH_PC;
            state      <= STATE_FETCH_PC;
            instr_done <= 1'b1;
          end else begin
            phase <= PH_EXEC;
            state <= rom_out.word;
          end
        end
        PH_EXEC: begin
          if (is_io_state(state) && !io_ack) begin
            state <= state;
          end else if (last_q) begin
            phase      <= PH_FETCH_PC;
            state      <= STATE_FETCH_PC;
            instr_done <= 1'b1;
          end else begin
            step   <= step + STEP_W'(1);
            state  <= rom_out.word;
            last_q <= rom_out.last;
          end
        end
        PH_HALT: begin
          state <= STATE_HALT;
        end
        default: begin
          // Corrupted phase: park safely and flag it
          phase <= PH_HALT;
          state <= STATE_HALT;
          fault <= 1'b1;
        end
      endcase
    end else begin
      instr_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench for instr_sequencer. Each driven cycle
// pushes the expected {state, instr_done, fault}; after the clock edge the
// entry is popped and compared with the DUT outputs.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [4:0] opcode;
  logic       io_ack;
  logic [7:0] state;
  logic       instr_done;
  logic       fault;

  typedef struct packed {
    logic [7:0] st;
    logic       done;
    logic       flt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  instr_sequencer #(.OPC_W(5), .MAX_STEPS(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .opcode     (opcode),
    .io_ack     (io_ack),
    .state      (state),
    .instr_done (instr_done),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop one scoreboard entry and compare against the current outputs
  task automatic compare_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_state"}, {24'd0, state}, {24'd0, e.st});
      check_val({tag, "_done"},  {31'd0, instr_done}, {31'd0, e.done});
      check_val({tag, "_fault"}, {31'd0, fault}, {31'd0, e.flt});
    end
  endtask

  // Drive one cycle of inputs, record expectation, clock, compare
  task automatic cyc(input logic e, input logic a, input logic [4:0] op,
                     input logic [7:0] es, input logic ed, input logic ef,
                     input string tag);
    en     = e;
    io_ack = a;
    opcode = op;
    exp_q.push_back('{st: es, done: ed, flt: ef});
    @(posedge clk);
    #2;
    compare_out(tag);
  endtask

  // Reference execute sequences, straight from the opcode table
  function automatic int exp_len(input logic [4:0] op);
    case (op)
      OP_NOP: return 0;
      OP_MOV, OP_ROUT, OP_HALT: return 1;
      OP_ALU, OP_LDI, OP_LDR, OP_STR, OP_PUSH, OP_JMP: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [7:0] exp_word(input logic [4:0] op, input int i);
    logic [23:0] s;
    case (op)
      OP_ALU:  s = {STATE_ALU_EXEC, STATE_ALU_OUT, 8'h00};
      OP_LDI:  s = {STATE_FETCH_PC, STATE_SET_REG, 8'h00};
      OP_LD:   s = {STATE_FETCH_PC, STATE_LOAD_ADDR, STATE_SET_REG};
      OP_ST:   s = {STATE_FETCH_PC, STATE_LOAD_ADDR, STATE_SET_MEM};
      OP_LDR:  s = {STATE_SET_MAR, STATE_SET_REG, 8'h00};
      OP_STR:  s = {STATE_SET_MAR, STATE_SET_MEM, 8'h00};
      OP_MOV:  s = {STATE_MOVE_REG, 16'h0000};
      OP_PUSH: s = {STATE_FETCH_SP, STATE_STACK_REG, 8'h00};
      OP_POP:  s = {STATE_INC_SP, STATE_FETCH_SP, STATE_SET_REG};
      OP_JMP:  s = {STATE_FETCH_PC, STATE_JUMP, 8'h00};
      OP_CALL: s = {STATE_FETCH_SP, STATE_STORE_PC, STATE_TMP_JUMP};
      OP_RET:  s = {STATE_INC_SP, STATE_FETCH_SP, STATE_RET};
      OP_MOUT: s = {STATE_FETCH_PC, STATE_LOAD_ADDR, STATE_MOUT_STORE};
      OP_ROUT: s = {STATE_ROUT_STORE, 16'h0000};
      default: s = 24'h000000;
    endcase
    return s[23 - 8*i -: 8];
  endfunction

  // Full instruction starting from FETCH_PC, IO acked immediately
  task automatic run_instr(input logic [4:0] op, input string tag);
    cyc(1'b1, 1'b1, op, STATE_FETCH_INST, 1'b0, 1'b0, {tag, "_fi"});
    cyc(1'b1, 1'b1, op, STATE_DECODE,     1'b0, 1'b0, {tag, "_dec"});
    for (int i = 0; i < exp_len(op); i++) begin
      cyc(1'b1, 1'b1, op, exp_word(op, i), 1'b0, 1'b0, $sformatf("%s_x%0d", tag, i));
    end
    cyc(1'b1, 1'b1, op, STATE_FETCH_PC, 1'b1, 1'b0, {tag, "_ret"});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.push_back('{st: STATE_FETCH_PC, done: 1'b0, flt: 1'b0});
    #1;
    compare_out("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    opcode = OP_NOP;
    io_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    do_reset();

    // ALU: FI, DEC, ALU_EXEC, ALU_OUT, FETCH_PC with done
    cyc(1'b1, 1'b0, OP_ALU, STATE_FETCH_INST, 1'b0, 1'b0, "alu_fi");
    cyc(1'b1, 1'b0, OP_ALU, STATE_DECODE,     1'b0, 1'b0, "alu_dec");
    cyc(1'b1, 1'b0, OP_ALU, STATE_ALU_EXEC,   1'b0, 1'b0, "alu_ex");
    cyc(1'b1, 1'b0, OP_ALU, STATE_ALU_OUT,    1'b0, 1'b0, "alu_out");
    cyc(1'b1, 1'b0, OP_ALU, STATE_FETCH_PC,   1'b1, 1'b0, "alu_ret");

    // JMP, IR switches to HALT after DECODE
    cyc(1'b1, 1'b0, OP_JMP,  STATE_FETCH_INST, 1'b0, 1'b0, "jmp_fi");
    cyc(1'b1, 1'b0, OP_JMP,  STATE_DECODE,     1'b0, 1'b0, "jmp_dec");
    cyc(1'b1, 1'b0, OP_JMP,  STATE_FETCH_PC,   1'b0, 1'b0, "jmp_x0");
    cyc(1'b1, 1'b0, OP_HALT, STATE_JUMP,       1'b0, 1'b0, "jmp_x1");
    cyc(1'b1, 1'b0, OP_HALT, STATE_FETCH_PC,   1'b1, 1'b0, "jmp_ret");
    run_instr(OP_NOP, "after_jmp");

    // MOUT: io_ack high in a non-IO state is ignored; 3 low cycles then ack
    cyc(1'b1, 1'b0, OP_MOUT, STATE_FETCH_INST, 1'b0, 1'b0, "mout_fi");
    cyc(1'b1, 1'b0, OP_MOUT, STATE_DECODE,     1'b0, 1'b0, "mout_dec");
    cyc(1'b1, 1'b1, OP_MOUT, STATE_FETCH_PC,   1'b0, 1'b0, "mout_x0");
    cyc(1'b1, 1'b1, OP_MOUT, STATE_LOAD_ADDR,  1'b0, 1'b0, "mout_x1");
    cyc(1'b1, 1'b0, OP_MOUT, STATE_MOUT_STORE, 1'b0, 1'b0, "mout_io0");
    cyc(1'b1, 1'b0, OP_MOUT, STATE_MOUT_STORE, 1'b0, 1'b0, "mout_io1");
    cyc(1'b1, 1'b0, OP_MOUT, STATE_MOUT_STORE, 1'b0, 1'b0, "mout_io2");
    cyc(1'b1, 1'b0, OP_MOUT, STATE_MOUT_STORE, 1'b0, 1'b0, "mout_io3");
    cyc(1'b1, 1'b1, OP_MOUT, STATE_FETCH_PC,   1'b1, 1'b0, "mout_ret");

    // ROUT: ack during a frozen cycle is not consumed
    cyc(1'b1, 1'b0, OP_ROUT, STATE_FETCH_INST, 1'b0, 1'b0, "rout_fi");
    cyc(1'b1, 1'b0, OP_ROUT, STATE_DECODE,     1'b0, 1'b0, "rout_dec");
    cyc(1'b1, 1'b0, OP_ROUT, STATE_ROUT_STORE, 1'b0, 1'b0, "rout_x0");
    cyc(1'b0, 1'b1, OP_ROUT, STATE_ROUT_STORE, 1'b0, 1'b0, "rout_frz");
    cyc(1'b1, 1'b0, OP_ROUT, STATE_ROUT_STORE, 1'b0, 1'b0, "rout_wait");
    cyc(1'b1, 1'b1, OP_ROUT, STATE_FETCH_PC,   1'b1, 1'b0, "rout_ret");

    // CALL with freeze in STORE_PC, then async reset in TMP_JUMP
    cyc(1'b1, 1'b0, OP_CALL, STATE_FETCH_INST, 1'b0, 1'b0, "call_fi");
    cyc(1'b1, 1'b0, OP_CALL, STATE_DECODE,     1'b0, 1'b0, "call_dec");
    cyc(1'b1, 1'b0, OP_CALL, STATE_FETCH_SP,   1'b0, 1'b0, "call_x0");
    cyc(1'b1, 1'b0, OP_CALL, STATE_STORE_PC,   1'b0, 1'b0, "call_x1");
    cyc(1'b0, 1'b0, OP_CALL, STATE_STORE_PC,   1'b0, 1'b0, "call_frz0");
    cyc(1'b0, 1'b0, OP_CALL, STATE_STORE_PC,   1'b0, 1'b0, "call_frz1");
    cyc(1'b1, 1'b0, OP_CALL, STATE_TMP_JUMP,   1'b0, 1'b0, "call_x2");
    do_reset();

    // NOP x3 back to back
    run_instr(OP_NOP, "nop0");
    run_instr(OP_NOP, "nop1");
    run_instr(OP_NOP, "nop2");

    // Every remaining legal non-halting opcode
    for (int op = 1; op < 15; op++) begin
      run_instr(5'(op), $sformatf("op%0h", op));
    end

    // Legal HALT: terminal without fault
    cyc(1'b1, 1'b0, OP_HALT, STATE_FETCH_INST, 1'b0, 1'b0, "halt_fi");
    cyc(1'b1, 1'b0, OP_HALT, STATE_DECODE,     1'b0, 1'b0, "halt_dec");
    cyc(1'b1, 1'b0, OP_HALT, STATE_HALT,       1'b0, 1'b0, "halt_x0");
    cyc(1'b1, 1'b1, OP_NOP,  STATE_HALT,       1'b0, 1'b0, "halt_hold");
    do_reset();

    // Illegal opcode 5'h1F: HALT with sticky fault, 20 cycles of noise
    cyc(1'b1, 1'b0, 5'h1F, STATE_FETCH_INST, 1'b0, 1'b0, "ill_fi");
    cyc(1'b1, 1'b0, 5'h1F, STATE_DECODE,     1'b0, 1'b0, "ill_dec");
    cyc(1'b1, 1'b0, 5'h1F, STATE_HALT,       1'b0, 1'b1, "ill_halt");
    for (int i = 0; i < 20; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
          STATE_HALT, 1'b0, 1'b1, $sformatf("ill_hold%0d", i));
    end
    do_reset();
    cyc(1'b1, 1'b0, OP_NOP, STATE_FETCH_INST, 1'b0, 1'b0, "post_fi");

    // Illegal boundary 5'h10
    cyc(1'b1, 1'b0, OP_ILLEGAL_MIN, STATE_DECODE, 1'b0, 1'b0, "ill10_dec");
    cyc(1'b1, 1'b0, OP_ILLEGAL_MIN, STATE_HALT,   1'b0, 1'b1, "ill10_halt");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Micro-sequencer that generates the 8-bit `state` word consumed by the control-signal decoder. It walks each instruction through fetch, decode and a per-opcode list of execute states, then returns to fetch. It sits between the instruction register (opcode source) and the control decoder (control-line sink). It stalls on IO handshakes and halts on `HALT` or on an illegal opcode.

## Interface
Parameters:
- `OPC_W`, 5: opcode width taken from the instruction register.
- `MAX_STEPS`, 3: maximum number of execute states per instruction; sets the step counter width to 2 bits.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  run enable; low freezes all registers (single-step/debug).
- `opcode`  in  `OPC_W`  opcode field of the IR; sampled only in `STATE_DECODE`.
- `io_ack`  in  1  IO interface has accepted the `c_go` transfer.
- `state`  out  8  current state word, registered; drives the control decoder.
- `instr_done`  out  1  registered one-cycle pulse after an instruction retires.
- `fault`  out  1  sticky; high once an illegal opcode has been decoded.

## Operation
- Fixed prefix for every instruction: `STATE_FETCH_PC` → `STATE_FETCH_INST` → `STATE_DECODE`.
- `STATE_DECODE`:
  - Latches `opcode` into an internal `op_q` and clears the step counter.
  - Jumps to the first execute state of `op_q`.
  - Later changes on the IR do not affect the running sequence.
- Execute sequences (step 0, 1, 2):
  - NOP: none; DECODE → FETCH_PC.
  - ALU: ALU_EXEC, ALU_OUT.
  - LDI: FETCH_PC, SET_REG.
  - LD: FETCH_PC, LOAD_ADDR, SET_REG.
  - ST: FETCH_PC, LOAD_ADDR, SET_MEM.
  - LDR (register-indirect): SET_MAR, SET_REG.
  - STR: SET_MAR, SET_MEM.
  - MOV: MOVE_REG.
  - PUSH: FETCH_SP, STACK_REG.
  - POP: INC_SP, FETCH_SP, SET_REG.
  - JMP/Jcc: FETCH_PC, JUMP. Condition evaluation stays in the decoder; the sequencer always runs both states.
  - CALL: FETCH_SP, STORE_PC, TMP_JUMP.
  - RET: INC_SP, FETCH_SP, RET.
  - MOUT: FETCH_PC, LOAD_ADDR, MOUT_STORE.
  - ROUT: ROUT_STORE.
  - HALT: HALT.
- After the last step of a sequence, the next state is FETCH_PC and `instr_done` pulses in that FETCH_PC cycle.
- IO stall: in MOUT_STORE or ROUT_STORE, `state` holds until a cycle with `io_ack`=1. It advances on the following edge.
- HALT: terminal. `state` stays HALT regardless of `en`/`io_ack`; only `rst_n` exits.
- Illegal opcode (5'h10–5'h1F): DECODE → HALT and `fault`←1. `instr_done` is not pulsed.
- `en`=0: `state`, step counter and `op_q` hold; `instr_done` is forced 0 in frozen cycles; `fault` holds.

## Timing
- Reset values (asynchronous, while `rst_n`=0): `state`=STATE_FETCH_PC, step=0, `op_q`=NOP, `instr_done`=0, `fault`=0.
- Reset mid-instruction aborts it immediately; first state after release is FETCH_PC.
- One state per enabled clock, except IO stalls and HALT.
- Instruction latency = 3 + n execute cycles (+ IO wait). Examples: NOP 3, ALU 5, CALL 6.
- `io_ack` is sampled only in the IO states; `io_ack` high elsewhere is ignored.
- `io_ack` and `en`=0 in the same cycle: the freeze wins and the ack is not consumed.
- `instr_done` pulses exactly 1 cycle per retired instruction. Back-to-back instructions give pulses 3+n cycles apart.

## Structure
- `symbols.vh` gains:
  - `STATE_DECODE`, using an 8-bit encoding distinct from all existing STATE_ values.
  - `OP_*` opcode constants, 5'h00–5'h0F legal.
  - `OP_ILLEGAL_MIN` = 5'h10.
- Existing STATE_ encodings are reused unchanged.
- Sub-module `seq_rom`: purely combinational, (`op_q`, step) → {state word, last flag, legal flag}.
- The top level holds the FSM (prefix / exec / halt), step counter, `op_q`, IO stall, `instr_done` and `fault` registers.

## Test plan
- Release reset, opcode=OP_ALU, `en`=1 → states FETCH_PC, FETCH_INST, DECODE, ALU_EXEC, ALU_OUT, FETCH_PC. `instr_done`=1 only in the 6th cycle.
- OP_JMP, IR changed to OP_HALT after DECODE → JUMP still follows FETCH_PC, and the next instruction fetch proceeds normally.
- OP_MOUT, `io_ack` low for 3 cycles then high → MOUT_STORE present for 4 cycles, then FETCH_PC with `instr_done`=1.
- opcode=5'h1F → DECODE then HALT, `fault`=1. State remains HALT for 20 cycles with `en`/`io_ack` toggling; `rst_n` pulse → FETCH_PC, `fault`=0.
- OP_CALL, `en` low for 2 cycles during STORE_PC → STORE_PC held 3 cycles, TMP_JUMP next. `rst_n` asserted asynchronously mid-TMP_JUMP → `state`=FETCH_PC before the next clock edge.
- OP_NOP ×3 back-to-back → period 3 cycles, three `instr_done` pulses 3 cycles apart.
